dcfeb_pkt_arbiter: RTL
======================

# dcfeb_pkt_arbiter

Round-robin packet scheduler that shares the single downstream readout path between NCH DCFEB receive channels. Each channel's frame processor writes checked frame words into a per-channel first-word-fall-through FIFO and pulses its CRC-check-valid strobe with the good/bad CRC result. This block counts completed packets per channel and queues their CRC status. It grants one channel at a time and streams exactly one whole packet per grant onto a valid/ready output with end-of-packet and error flags.

## Interface
Parameters:
- NCH, 7, number of receive channels (1..8)
- MAX_WORDS, 812, max words per packet before forced abort
- TMO, 1023, idle-FIFO timeout in CLK cycles during transfer (timeout build only)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- PKT_DONE  in  NCH  one-cycle pulse per channel when a packet is complete in its FIFO (CRC check valid)
- PKT_GOOD  in  NCH  CRC-good per channel, sampled when PKT_DONE=1
- FIFO_EMPTY  in  NCH  per-channel FWFT FIFO empty
- FIFO_DOUT  in  17*NCH  per-channel FIFO head; bit16 = last word of packet, [15:0] data
- FIFO_REN  out  NCH  per-channel pop, one-hot or zero
- OUT_DATA  out  16  packet word
- OUT_VALID  out  1  OUT_DATA holds a word
- OUT_READY  in  1  downstream accepts word when OUT_VALID&OUT_READY
- OUT_LAST  out  1  qualifies last word of packet
- OUT_BAD  out  1  valid with OUT_LAST: bad CRC, length abort or timeout
- CH_SEL  out  3  granted channel
- BUSY  out  1  a grant is active
- OVFL  out  NCH  sticky pending-counter overflow per channel

## Operation
- Per channel: 4-bit pending counter and 16-entry CRC-status queue. PKT_DONE increments the counter and pushes PKT_GOOD. Packet completion decrements the counter and pops the queue.
- PKT_DONE and completion on the same channel in the same cycle: counter unchanged; push and pop both occur.
- PKT_DONE while counter=15: counter holds, push dropped, OVFL bit set; cleared only by RST.
- States: IDLE, XFER, FLUSH, GAP.
  - IDLE: if any counter is nonzero, grant the first nonzero channel after the last-served one, wrapping. Register CH_SEL, go to XFER.
  - XFER: FIFO_REN[CH_SEL] = ~FIFO_EMPTY & (~OUT_VALID | OUT_READY). On pop, the output register loads the head word, and OUT_LAST = bit16.
    - Word counter (10 bits) increments per pop.
    - On reaching MAX_WORDS without bit16: emit that word with OUT_LAST=1 and OUT_BAD=1, then go to FLUSH.
  - On acceptance of the OUT_LAST word: OUT_BAD = ~status head (OR abort/timeout), decrement the counter, pop status, go to GAP.
  - FLUSH: pop the granted FIFO each non-empty cycle without output until a bit16 word is popped, then decrement the counter, pop status, go to GAP.
  - GAP: one cycle, BUSY=0, then IDLE.
- Reset values: FIFO_REN=0, OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, OUT_BAD=0, CH_SEL=NCH-1 (so channel 0 is served first), BUSY=0, OVFL=0, all counters and queues empty, state IDLE.
- RST mid-packet: everything returns to reset values immediately; partially read FIFO contents are not flushed by this block.

## Timing
- PKT_DONE at cycle t: counter updated at t+1, grant and XFER at t+2, first FIFO_REN at t+2, OUT_VALID at t+3.
- Back-to-back streaming at one word per cycle while OUT_READY=1 and FIFO non-empty.
- OUT_VALID/OUT_DATA/OUT_LAST/OUT_BAD hold stable while OUT_VALID & ~OUT_READY.
- Packet gap: last-word acceptance, then GAP, then IDLE, then next grant; minimum 3 cycles between packets.
- BUSY=1 from grant until the GAP cycle.

## Configuration
- PKT_ARB_TIMEOUT_EN defined:
  - In XFER, a counter counts consecutive cycles with the granted FIFO empty and the last word not yet popped.
  - At TMO, the block emits OUT_VALID with OUT_LAST=1, OUT_BAD=1, OUT_DATA=16'h0000.
  - It then decrements the pending counter, pops status, goes to GAP, and the remainder of the packet stays in the FIFO.
- Undefined: no timeout logic; XFER waits indefinitely on an empty FIFO.

## Test plan
- Ch2 PKT_DONE with PKT_GOOD=1, 4-word packet, OUT_READY=1 -> CH_SEL=2, OUT_VALID at t+3, 4 consecutive words, OUT_LAST on word 4, OUT_BAD=0, counter back to 0.
- Ch0, ch3, ch6 each have one pending packet, last-served=3 -> service order 6, 0, 3, each separated by ≥3 cycles.
- OUT_READY toggled 1-0-1 mid-packet -> data held stable, no word duplicated or dropped, FIFO_REN only on accepted slots.
- Ch1 packet with PKT_GOOD=0 -> OUT_BAD=1 on last word. Packet of 900 words without bit16 until word 900 -> abort at word 812 with OUT_BAD=1, 88 words flushed, next packet delivered intact.
- 16 PKT_DONE on ch4 with no readout -> counter 15, OVFL[4]=1. Simultaneous PKT_DONE and completion on ch4 -> counter unchanged.
- With PKT_ARB_TIMEOUT_EN and TMO=1023, FIFO empty after 2 words -> at 1023 empty cycles, terminal word 0x0000 with OUT_LAST=1, OUT_BAD=1. RST asserted mid-XFER -> all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/dcfeb_pkt_arbiter.sv
// dcfeb_pkt_arbiter: round-robin scheduler streaming whole packets from NCH FWFT FIFOs onto one valid/ready port.
// Latency: PKT_DONE at t -> grant and first FIFO pop at t+2 -> OUT_VALID at t+3; then one word per cycle.
// Backpressure: output register holds while OUT_VALID & ~OUT_READY; FIFO pops only into a free or draining slot.
// Optional build macro PKT_ARB_TIMEOUT_EN: terminate a transfer whose FIFO stays empty for TMO cycles.
module dcfeb_pkt_arbiter #(
    parameter int NCH       = 7,
    parameter int MAX_WORDS = 812,
    parameter int TMO       = 1023
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NCH-1:0]      PKT_DONE,
    input  logic [NCH-1:0]      PKT_GOOD,
    input  logic [NCH-1:0]      FIFO_EMPTY,
    input  logic [17*NCH-1:0]   FIFO_DOUT,
    output logic [NCH-1:0]      FIFO_REN,
    output logic [15:0]         OUT_DATA,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic                OUT_LAST,
    output logic                OUT_BAD,
    output logic [2:0]          CH_SEL,
    output logic                BUSY,
    output logic [NCH-1:0]      OVFL
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_FLUSH, S_GAP} state_t;

    state_t         state;
    logic [3:0]     pend_cnt [NCH];
    logic [15:0]    stat_q   [NCH];
    logic [3:0]     stat_wp  [NCH];
    logic [3:0]     stat_rp  [NCH];
    logic [9:0]     word_cnt;
    logic [9:0]     word_cnt_nx;
    logic           abort_r;

    logic [16:0]    head;
    logic           head_empty;
    logic           head_good;
    logic           pop;
    logic           cmpl;
    logic [NCH-1:0] cmpl_vec;
    logic           gnt_found;
    logic [2:0]     gnt_ch;
    int             gnt_idx;
    logic           tmo_fire;

    assign word_cnt_nx = word_cnt + 10'd1;

    // Select the granted channel's FIFO head, empty flag and oldest CRC status
    always_comb begin
        head       = '0;
        head_empty = 1'b1;
        head_good  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (CH_SEL == 3'(i)) begin
                head       = FIFO_DOUT[i*17 +: 17];
                head_empty = FIFO_EMPTY[i];
                head_good  = stat_q[i][stat_rp[i]];
            end
        end
    end

    // Pop decision and packet completion; once the last word sits in the output register no further pops
    always_comb begin
        pop = 1'b0;
        case (state)
            S_XFER:  pop = ~head_empty & (~OUT_VALID | (OUT_READY & ~OUT_LAST));
            S_FLUSH: pop = ~head_empty;
            default: pop = 1'b0;
        endcase
        cmpl = ((state == S_XFER) & OUT_VALID & OUT_READY & OUT_LAST & ~abort_r)
             | ((state == S_FLUSH) & pop & head[16]);
        FIFO_REN = '0;
        cmpl_vec = '0;
        for (int i = 0; i < NCH; i++) begin
            if (CH_SEL == 3'(i)) begin
                FIFO_REN[i] = pop;
                cmpl_vec[i] = cmpl;
            end
        end
    end

    // Round-robin search: first channel with pending packets after the last-served one, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = CH_SEL;
        gnt_idx   = 0;
        for (int k = 1; k <= NCH; k++) begin
            gnt_idx = (int'(CH_SEL) + k) % NCH;
            if (!gnt_found && pend_cnt[gnt_idx] != 4'd0) begin
                gnt_found = 1'b1;
                gnt_ch    = 3'(gnt_idx);
            end
        end
    end

`ifdef PKT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt;
    logic          starved;

    assign starved  = (state == S_XFER) & head_empty & ~(OUT_VALID & OUT_LAST);
    assign tmo_fire = starved & (tmo_cnt == TW'(TMO - 1)) & (~OUT_VALID | OUT_READY);

    // Count consecutive empty-FIFO cycles while the packet end has not been seen; saturate while stalled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt <= '0;
        end else if (!starved) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TMO - 1)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // Without the timeout build TMO has no effect; XFER waits on an empty FIFO indefinitely
    assign tmo_fire = 1'b0 & (TMO > 0);
`endif

    // Per-channel pending counters and CRC-status queues; a simultaneous push and pop leaves the count alone
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVFL <= '0;
            for (int i = 0; i < NCH; i++) begin
                pend_cnt[i] <= 4'd0;
                stat_q[i]   <= 16'd0;
                stat_wp[i]  <= 4'd0;
                stat_rp[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (PKT_DONE[i] && cmpl_vec[i]) begin
                    stat_q[i][stat_wp[i]] <= PKT_GOOD[i];
                    stat_wp[i]            <= stat_wp[i] + 4'd1;
                    stat_rp[i]            <= stat_rp[i] + 4'd1;
                end else if (PKT_DONE[i]) begin
                    if (pend_cnt[i] == 4'd15) begin
                        OVFL[i] <= 1'b1;
                    end else begin
                        pend_cnt[i]           <= pend_cnt[i] + 4'd1;
                        stat_q[i][stat_wp[i]] <= PKT_GOOD[i];
                        stat_wp[i]            <= stat_wp[i] + 4'd1;
                    end
                end else if (cmpl_vec[i]) begin
                    pend_cnt[i] <= pend_cnt[i] - 4'd1;
                    stat_rp[i]  <= stat_rp[i] + 4'd1;
                end
            end
        end
    end

    // Grant/transfer/flush/gap sequencer with the registered output word
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            CH_SEL    <= 3'(NCH - 1);
            BUSY      <= 1'b0;
            OUT_DATA  <= 16'd0;
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
            OUT_BAD   <= 1'b0;
            word_cnt  <= 10'd0;
            abort_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        CH_SEL   <= gnt_ch;
                        BUSY     <= 1'b1;
                        word_cnt <= 10'd0;
                        abort_r  <= 1'b0;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (pop) begin
                        OUT_VALID <= 1'b1;
                        OUT_DATA  <= head[15:0];
                        word_cnt  <= word_cnt_nx;
                        if (head[16]) begin
                            OUT_LAST <= 1'b1;
                            OUT_BAD  <= ~head_good;
                        end else if (word_cnt_nx == 10'(MAX_WORDS)) begin
                            // Oversized packet: cut it here and drain the rest in FLUSH
                            OUT_LAST <= 1'b1;
                            OUT_BAD  <= 1'b1;
                            abort_r  <= 1'b1;
                        end else begin
                            OUT_LAST <= 1'b0;
                            OUT_BAD  <= 1'b0;
                        end
                    end else if (tmo_fire) begin
                        OUT_VALID <= 1'b1;
                        OUT_DATA  <= 16'h0000;
                        OUT_LAST  <= 1'b1;
                        OUT_BAD   <= 1'b1;
                    end else if (OUT_VALID && OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        OUT_LAST  <= 1'b0;
                        OUT_BAD   <= 1'b0;
                        if (OUT_LAST) begin
                            if (abort_r) begin
                                state <= S_FLUSH;
                            end else begin
                                state <= S_GAP;
                                BUSY  <= 1'b0;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (pop && head[16]) begin
                        state <= S_GAP;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
